// File: rtl/rv32i_pkg.sv
// Shared RV32I data-memory definitions: funct3 load/store codes, bridge FSM states, bus widths.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package rv32i_pkg;

  localparam int XLEN = 32;
  localparam int BE_W = XLEN / 8;

  // funct3 encodings shared by loads and stores (size in [1:0], unsigned flag in [2])
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_bridge_if.sv
// Word-wide memory bus between the load/store bridge and the data memory.
// Latency: none (wires only).
// Backpressure: master holds valid and its payload steady until ready is seen high.
interface dmem_bridge_if;
  import rv32i_pkg::*;

  logic            bus_valid;
  logic            bus_we;
  logic [XLEN-1:0] bus_addr;
  logic [XLEN-1:0] bus_wdata;
  logic [BE_W-1:0] bus_be;
  logic            bus_ready;
  logic [XLEN-1:0] bus_rdata;

  modport master (
    output bus_valid, bus_we, bus_addr, bus_wdata, bus_be,
    input  bus_ready, bus_rdata
  );

  modport slave (
    input  bus_valid, bus_we, bus_addr, bus_wdata, bus_be,
    output bus_ready, bus_rdata
  );

endinterface

// File: rtl/dmem_lane_fmt.sv
// Byte-lane logic: store shift/byte enables plus legality check, and load extract/extend.
// Latency: purely combinational.
// Backpressure: none; store side looks at the live request, load side at the captured one.
module dmem_lane_fmt
  import rv32i_pkg::*;
(
  input  logic            st_we_i,
  input  logic [2:0]      st_f3_i,
  input  logic [1:0]      st_off_i,
  input  logic [XLEN-1:0] st_wdata_i,
  output logic [XLEN-1:0] st_wdata_o,
  output logic [BE_W-1:0] st_be_o,
  output logic            legal_o,
  input  logic [2:0]      ld_f3_i,
  input  logic [1:0]      ld_off_i,
  input  logic [XLEN-1:0] ld_rdata_i,
  output logic [XLEN-1:0] ld_data_o
);

  logic [XLEN-1:0] byte_sh;
  logic [XLEN-1:0] half_sh;

  // Store lanes and alignment/encoding check; loads get the same lane mask
  always_comb begin
    st_wdata_o = st_wdata_i;
    st_be_o    = '1;
    legal_o    = 1'b0;
    case (st_f3_i[1:0])
      2'b00: begin
        st_be_o    = 4'b0001 << st_off_i;
        st_wdata_o = {4{st_wdata_i[7:0]}};
        legal_o    = 1'b1;
      end
      2'b01: begin
        st_be_o    = 4'b0011 << {st_off_i[1], 1'b0};
        st_wdata_o = {2{st_wdata_i[15:0]}};
        legal_o    = ~st_off_i[0];
      end
      2'b10: begin
        st_be_o = '1;
        legal_o = (st_off_i == 2'b00);
      end
      default: legal_o = 1'b0;
    endcase
    // Unsigned variants exist only for byte/half loads
    if (st_f3_i[2] && (st_we_i || st_f3_i[1])) begin
      legal_o = 1'b0;
    end
  end

  assign byte_sh = ld_rdata_i >> {ld_off_i, 3'b000};
  assign half_sh = ld_rdata_i >> {ld_off_i[1], 4'b0000};

  // Load lane extract with sign or zero extension
  always_comb begin
    ld_data_o = '0;
    case (ld_f3_i)
      F3_B:    ld_data_o = {{24{byte_sh[7]}}, byte_sh[7:0]};
      F3_BU:   ld_data_o = {24'd0, byte_sh[7:0]};
      F3_H:    ld_data_o = {{16{half_sh[15]}}, half_sh[15:0]};
      F3_HU:   ld_data_o = {16'd0, half_sh[15:0]};
      F3_W:    ld_data_o = ld_rdata_i;
      default: ld_data_o = '0;
    endcase
  end

endmodule

// File: rtl/dmem_bridge.sv
// Core load/store to word-bus bridge; stalls the core until the bus completes. Optional bus
// timeout via DMEM_BRIDGE_TIMEOUT_EN. Latency: 2 stall cycles minimum, 1 for a faulted access.
// Backpressure: waits in REQ with the bus payload held until bus_ready.
module dmem_bridge
  import rv32i_pkg::*;
#(
  parameter int WAIT_MAX = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  input  logic             req_we,
  input  logic [XLEN-1:0]  req_addr,
  input  logic [XLEN-1:0]  req_wdata,
  input  logic [2:0]       req_f3,
  output logic             stall,
  output logic [XLEN-1:0]  readData,
  output logic             err,
  dmem_bridge_if.master    bus
);

  state_t          state_q, state_d;
  logic            bus_we_q, bus_we_d;
  logic [XLEN-1:0] bus_addr_q, bus_addr_d;
  logic [XLEN-1:0] bus_wdata_q, bus_wdata_d;
  logic [BE_W-1:0] bus_be_q, bus_be_d;
  logic [2:0]      ld_f3_q, ld_f3_d;
  logic [1:0]      ld_off_q, ld_off_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            err_q, err_d;

  logic [XLEN-1:0] fmt_wdata;
  logic [BE_W-1:0] fmt_be;
  logic            fmt_legal;
  logic [XLEN-1:0] fmt_ld_data;

`ifdef DMEM_BRIDGE_TIMEOUT_EN
  logic [31:0]     cnt_q, cnt_d;
`else
  localparam int unused_wait_max = WAIT_MAX;
`endif

  dmem_lane_fmt u_fmt (
    .st_we_i    (req_we),
    .st_f3_i    (req_f3),
    .st_off_i   (req_addr[1:0]),
    .st_wdata_i (req_wdata),
    .st_wdata_o (fmt_wdata),
    .st_be_o    (fmt_be),
    .legal_o    (fmt_legal),
    .ld_f3_i    (ld_f3_q),
    .ld_off_i   (ld_off_q),
    .ld_rdata_i (bus.bus_rdata),
    .ld_data_o  (fmt_ld_data)
  );

  // Next-state, request capture and stall/valid generation
  always_comb begin
    state_d     = state_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_be_d    = bus_be_q;
    ld_f3_d     = ld_f3_q;
    ld_off_d    = ld_off_q;
    rdata_d     = rdata_q;
    err_d       = 1'b0;
`ifdef DMEM_BRIDGE_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    stall         = 1'b0;
    bus.bus_valid = 1'b0;
    case (state_q)
      IDLE: begin
        stall = req_valid;
        if (req_valid) begin
          if (fmt_legal) begin
            state_d     = REQ;
            bus_we_d    = req_we;
            bus_addr_d  = {req_addr[XLEN-1:2], 2'b00};
            bus_wdata_d = fmt_wdata;
            bus_be_d    = fmt_be;
            ld_f3_d     = req_f3;
            ld_off_d    = req_addr[1:0];
`ifdef DMEM_BRIDGE_TIMEOUT_EN
            cnt_d       = '0;
`endif
          end else begin
            // Faulted access never touches the bus
            state_d = DONE;
            err_d   = 1'b1;
            rdata_d = '0;
          end
        end
      end
      REQ: begin
        stall         = 1'b1;
        bus.bus_valid = 1'b1;
        if (bus.bus_ready) begin
          state_d = DONE;
          rdata_d = bus_we_q ? '0 : fmt_ld_data;
        end
`ifdef DMEM_BRIDGE_TIMEOUT_EN
        else if (cnt_q + 32'd1 == 32'(WAIT_MAX)) begin
          state_d = DONE;
          err_d   = 1'b1;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
`endif
      end
      // One release cycle, then back to IDLE without looking at req_valid
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and captured-request registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_be_q    <= '0;
      ld_f3_q     <= '0;
      ld_off_q    <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_be_q    <= bus_be_d;
      ld_f3_q     <= ld_f3_d;
      ld_off_q    <= ld_off_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

`ifdef DMEM_BRIDGE_TIMEOUT_EN
  // Bus wait counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`endif

  assign bus.bus_we    = bus_we_q;
  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_wdata = bus_wdata_q;
  assign bus.bus_be    = bus_be_q;
  assign readData      = rdata_q;
  assign err           = err_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed bench for dmem_bridge: transaction-level model builds a per-cycle expectation queue.
// Latency: checks every cycle on the falling edge.
// Backpressure: bench plays the bus slave and chooses which REQ cycle raises bus_ready.
module tb_dmem_bridge;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_f3;
  logic        stall;
  logic [31:0] readData;
  logic        err;

  dmem_bridge_if bus_if ();

  dmem_bridge #(.WAIT_MAX(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_f3    (req_f3),
    .stall     (stall),
    .readData  (readData),
    .err       (err),
    .bus       (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit          stall;
    bit          bvld;
    bit          err;
    bit          crd;
    logic [31:0] rd;
    bit          cbus;
    logic [31:0] addr;
    bit          we;
    bit          cwd;
    logic [31:0] wdata;
    logic [3:0]  be;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, want);
    end
  endtask

  // ---------------- reference model (spec rules as arithmetic) ----------------
  function automatic bit m_legal(input bit we, input logic [2:0] f3, input logic [31:0] a);
    int sz;
    sz = int'(f3 % 4);
    if (sz == 3) return 1'b0;
    if (f3 >= 3'd4 && (we || sz == 2)) return 1'b0;
    if (sz == 1 && (a % 2) != 0) return 1'b0;
    if (sz == 2 && (a % 4) != 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [1:0] off,
                                         input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * off)) & 32'hFF;
    h = (w >> (16 * off[1])) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 32'h80)   ? (b | 32'hFFFFFF00) : b;
      3'b100:  return b;
      3'b001:  return (h >= 32'h8000) ? (h | 32'hFFFF0000) : h;
      3'b101:  return h;
      3'b010:  return w;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      3'b000:  return 4'(1 << off);
      3'b001:  return 4'(3 << off);
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] w);
    case (f3)
      3'b000:  return (w & 32'hFF) * 32'h01010101;
      3'b001:  return (w & 32'hFFFF) * 32'h00010001;
      default: return w;
    endcase
  endfunction

  task automatic push(input bit s, input bit v, input bit er, input bit crd, input logic [31:0] rd,
                      input bit cbus, input logic [31:0] a, input bit we, input bit cwd,
                      input logic [31:0] wd, input logic [3:0] be);
    exp_t r;
    r.stall = s;  r.bvld = v;  r.err = er;  r.crd = crd;  r.rd = rd;
    r.cbus = cbus; r.addr = a; r.we = we;  r.cwd = cwd;  r.wdata = wd; r.be = be;
    exp_q.push_back(r);
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("stall", 32'(stall), 32'(e.stall));
      chk("bus_valid", 32'(bus_if.bus_valid), 32'(e.bvld));
      chk("err", 32'(err), 32'(e.err));
      if (e.crd) chk("readData", readData, e.rd);
      if (e.cbus) begin
        chk("bus_addr", bus_if.bus_addr, e.addr);
        chk("bus_we", 32'(bus_if.bus_we), 32'(e.we));
        if (e.cwd) begin
          chk("bus_wdata", bus_if.bus_wdata, e.wdata);
          chk("bus_be", 32'(bus_if.bus_be), 32'(e.be));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  // nrdy: REQ cycle (1-based) in which the bus slave raises bus_ready
  task automatic access(input bit we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rdw, input int nrdy);
    bit          ok;
    logic [31:0] exp_rd;
    ok     = m_legal(we, f3, a);
    exp_rd = (we || !ok) ? 32'h0 : m_load(f3, a[1:0], rdw);
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd; req_f3 = f3;
    bus_if.bus_ready = 1'b0; bus_if.bus_rdata = ~rdw;
    push(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0);
    if (ok) begin
      for (int k = 1; k <= nrdy; k++) begin
        @(posedge clk); #1;
        bus_if.bus_ready = (k == nrdy);
        bus_if.bus_rdata = (k == nrdy) ? rdw : ~rdw;
        push(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, a & 32'hFFFFFFFC, we, we,
             m_wdata(f3, wd), m_be(f3, a[1:0]));
      end
      @(posedge clk); #1;
      bus_if.bus_ready = 1'b0; bus_if.bus_rdata = ~rdw;
      push(1'b0, 1'b0, 1'b0, 1'b1, exp_rd, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0);
    end else begin
      @(posedge clk); #1;
      push(1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0);
    end
    // req_valid stayed high through DONE; the bridge must not reissue
    @(posedge clk); #1;
    req_valid = 1'b0;
    push(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0);
  endtask

  task automatic reset_mid_req();
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h300; req_f3 = 3'b010;
    bus_if.bus_ready = 1'b0;
    push(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0);
    @(posedge clk); #1;
    push(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h300, 1'b0, 1'b0, 32'h0, 4'h0);
    @(posedge clk); #1;
    chk("rst_pre_bus_valid", 32'(bus_if.bus_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_bus_valid", 32'(bus_if.bus_valid), 32'd0);
    chk("rst_bus_addr", bus_if.bus_addr, 32'h0);
    chk("rst_bus_be", 32'(bus_if.bus_be), 32'h0);
    chk("rst_readData", readData, 32'h0);
    chk("rst_stall_reqv1", 32'(stall), 32'd1);
    req_valid = 1'b0;
    #1 chk("rst_stall_reqv0", 32'(stall), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      push(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0);
    end
  endtask

`ifdef DMEM_BRIDGE_TIMEOUT_EN
  task automatic timeout_access();
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h400; req_f3 = 3'b010;
    bus_if.bus_ready = 1'b0;
    push(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      push(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h400, 1'b0, 1'b0, 32'h0, 4'h0);
    end
    @(posedge clk); #1;
    push(1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    push(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0);
  endtask
`endif

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0;
    req_wdata = 32'h0; req_f3 = 3'b000;
    bus_if.bus_ready = 1'b0; bus_if.bus_rdata = 32'h0;

    // Hand-computed pins on the model itself
    chk("pin_lb",   m_load(3'b000, 2'd3, 32'h80112233), 32'hFFFFFF80);
    chk("pin_lbu",  m_load(3'b100, 2'd3, 32'h80112233), 32'h00000080);
    chk("pin_lh",   m_load(3'b001, 2'd2, 32'h80112233), 32'hFFFF8011);
    chk("pin_lhu",  m_load(3'b101, 2'd2, 32'h80112233), 32'h00008011);
    chk("pin_sb_be", 32'(m_be(3'b000, 2'd1)), 32'h2);
    chk("pin_sb_wd", m_wdata(3'b000, 32'h000000A5), 32'hA5A5A5A5);
    chk("pin_sh_be", 32'(m_be(3'b001, 2'd2)), 32'hC);
    chk("pin_lw_mis", 32'(m_legal(1'b0, 3'b010, 32'h102)), 32'd0);
    chk("pin_st_f3", 32'(m_legal(1'b1, 3'b100, 32'h100)), 32'd0);

    // Reset state
    #2;
    chk("reset_bus_valid", 32'(bus_if.bus_valid), 32'd0);
    chk("reset_bus_we", 32'(bus_if.bus_we), 32'd0);
    chk("reset_bus_wdata", bus_if.bus_wdata, 32'h0);
    chk("reset_err", 32'(err), 32'd0);
    chk("reset_readData", readData, 32'h0);
    chk("reset_stall", 32'(stall), 32'd0);
    req_valid = 1'b1;
    #1 chk("reset_stall_reqv", 32'(stall), 32'd1);
    req_valid = 1'b0;
    #19 rst_n = 1'b1;

    access(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 3);
    access(1'b0, 3'b000, 32'h103, 32'h0, 32'h80112233, 1);
    access(1'b0, 3'b100, 32'h103, 32'h0, 32'h80112233, 2);
    access(1'b0, 3'b001, 32'h102, 32'h0, 32'h80112233, 1);
    access(1'b0, 3'b101, 32'h102, 32'h0, 32'h80112233, 1);
    access(1'b0, 3'b000, 32'h100, 32'h0, 32'h80112233, 1);
    access(1'b0, 3'b001, 32'h100, 32'h0, 32'h8011A233, 2);
    access(1'b1, 3'b000, 32'h101, 32'h000000A5, 32'h0, 1);
    access(1'b0, 3'b010, 32'h104, 32'h0, 32'h12345678, 1);
    access(1'b1, 3'b001, 32'h102, 32'hFFFF1234, 32'h0, 2);
    access(1'b1, 3'b010, 32'h200, 32'hCAFEF00D, 32'h0, 3);
    access(1'b0, 3'b010, 32'h10C, 32'h0, 32'h55AA55AA, 1);
    access(1'b0, 3'b010, 32'h102, 32'h0, 32'h11111111, 1);
    access(1'b0, 3'b001, 32'h101, 32'h0, 32'h11111111, 1);
    access(1'b0, 3'b011, 32'h100, 32'h0, 32'h11111111, 1);
    access(1'b1, 3'b100, 32'h100, 32'h77, 32'h0, 1);
    access(1'b0, 3'b110, 32'h100, 32'h0, 32'h11111111, 1);
    access(1'b0, 3'b010, 32'h108, 32'h0, 32'hA5A5F00F, 1);
    reset_mid_req();
    access(1'b0, 3'b010, 32'h110, 32'h0, 32'h0BADF00D, 2);
`ifdef DMEM_BRIDGE_TIMEOUT_EN
    timeout_access();
`endif

    @(posedge clk);
    @(posedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_bridge.md
DMEM_BRIDGE -- requirements
Module: dmem_bridge

Interface
REQ-001 Parameter WAIT_MAX, default 255, sets the maximum bus wait cycles before timeout (timeout build only).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 req_valid  in  1  core requests a load or store this cycle.
REQ-005 req_we  in  1  1 = store, 0 = load.
REQ-006 req_addr  in  32  byte address (core ALU result).
REQ-007 req_wdata  in  32  store data, unshifted, LSB-aligned.
REQ-008 req_f3  in  3  funct3 size/sign code.
REQ-009 stall  out  1  core holds PC and register write while high.
REQ-010 readData  out  32  formatted load result.
REQ-011 err  out  1  one-cycle pulse for misaligned/illegal access or timeout.
REQ-012 bus_valid, bus_we  out  1 each  bus request and direction.
REQ-013 bus_addr  out  32  word-aligned address (bits [1:0] = 0).
REQ-014 bus_wdata  out  32  lane-shifted store data; bus_be  out  4  byte enables.
REQ-015 bus_ready  in  1, bus_rdata  in  32  bus completion and read word.

Function
REQ-016 FSM states: IDLE, REQ, DONE.
REQ-017 IDLE, req_valid=1, legal aligned access: stall=1 combinationally; capture request; next state REQ.
REQ-018 REQ: bus_valid=1; bus_addr/we/wdata/be stay stable until bus_ready is sampled high.
REQ-019 REQ with bus_ready=1: latch formatted readData (0 for stores); next state DONE; stall stays 1 in that cycle.
REQ-020 DONE: stall=0 for exactly one cycle, readData valid; next state IDLE regardless of req_valid, so the same instruction never reissues.
REQ-021 Load formatting: 000 LB and 100 LBU select byte addr[1:0]; 001 LH and 101 LHU select half addr[1]; 010 LW takes the full word; LB/LH sign-extend, LBU/LHU zero-extend.
REQ-022 Store lanes: SB gives be=0001<<addr[1:0] with byte replicated x4; SH gives be=0011<<(2*addr[1]) with half replicated x2; SW gives be=1111.
REQ-023 Misaligned access (half with addr[0]=1, word with addr[1:0]!=0) or illegal f3 (011, 110, 111; store f3 >010): no bus transaction; IDLE->DONE directly; err=1 in DONE; readData=0.
REQ-024 err is 0 in every cycle other than the DONE cycle of a faulted request.
REQ-025 Minimum latency is 2 stall cycles (bus_ready high on first REQ cycle); a faulted request costs 1 stall cycle.

Reset
REQ-026 rst_n low immediately forces state IDLE, bus_valid=0, bus_we=0, bus_be=0, bus_addr=0, bus_wdata=0, readData=0, err=0, and the timeout counter to 0.
REQ-027 Reset mid-REQ abandons the transaction; no completion is reported after release.
REQ-028 stall after reset depends only on IDLE and req_valid.

Configuration
REQ-029 With DMEM_BRIDGE_TIMEOUT_EN defined, a counter clears on REQ entry and increments each REQ cycle without bus_ready; reaching WAIT_MAX drops bus_valid and moves to DONE with err=1 and readData=0.
REQ-030 Without DMEM_BRIDGE_TIMEOUT_EN, no counter exists, WAIT_MAX is unused, and REQ waits indefinitely for bus_ready.

Structure
REQ-031 Shared package rv32i_pkg holds the funct3 load/store encodings, the FSM state enum, and the bus width constants.
REQ-032 Sub-module dmem_lane_fmt (combinational) performs store lane shift/byte-enable generation, load extract/extension, and the alignment check.

Verification
REQ-033 LW addr 0x100, bus_ready on 3rd REQ cycle, rdata 0xDEADBEEF -> stall high 4 cycles; DONE readData=0xDEADBEEF; err=0.
REQ-034 LB addr 0x103, rdata 0x80112233 -> readData=0xFFFFFF80; LBU same -> 0x00000080; LH addr 0x102 -> 0xFFFF8011.
REQ-035 SB addr 0x101 wdata 0x000000A5 -> bus_be=0010, bus_wdata=0xA5A5A5A5, bus_addr=0x100; SH addr 0x102 -> be=1100.
REQ-036 LW addr 0x102 -> no bus_valid; one stall cycle; err pulse; readData=0.
REQ-037 rst_n low during REQ -> bus_valid low asynchronously; after release, IDLE with no err or DONE cycle.
REQ-038 With DMEM_BRIDGE_TIMEOUT_EN and WAIT_MAX=4, bus_ready held low -> bus_valid drops after 4 REQ cycles; err=1; stall released.
